// File: rtl/spart_rx.sv
// spart_rx: SPART receive half, 8N1 deserialiser with bus read port.
// Define SPART_RX_FIFO_EN to replace the single buffer with a FIFO.
module spart_rx #(
    parameter int SAMPLE_TICK = 7,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rxd,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] addr,
    inout  wire  [7:0] bus_data,
    output logic       rda,
    output logic       ferr,
    output logic       oerr
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [3:0] SAMPLE = 4'(SAMPLE_TICK);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spart_rx: FIFO_DEPTH must be a power of 2, at least 2");
    end

    state_t     state, state_nx;
    logic       rx_meta, rxs;
    logic [3:0] tick, tick_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shift, shift_nx;
    logic       store, store_bad;
    logic       rd_acc, rd_acc_q, pop;
    logic [7:0] head_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tick    <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tick_nx    = tick;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        store      = 1'b0;
        store_bad  = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nx = START;
                        tick_nx  = 4'd0;
                    end
                end
                START: begin
                    if (tick == SAMPLE) begin
                        if (!rxs) begin
                            state_nx   = DATA;
                            tick_nx    = 4'd0;
                            bit_cnt_nx = 3'd0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tick_nx = tick + 4'd1;
                    end
                end
                DATA: begin
                    tick_nx = tick + 4'd1;
                    if (tick == 4'd15) begin
                        shift_nx[bit_cnt] = rxs;
                        bit_cnt_nx        = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nx = STOP;
                            tick_nx  = 4'd0;
                        end
                    end
                end
                STOP: begin
                    tick_nx = tick + 4'd1;
                    if (tick == 4'd15) begin
                        store     = 1'b1;
                        store_bad = !rxs;
                        tick_nx   = 4'd0;
                        state_nx  = rxs ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // a held-low break must return high before a new frame
                    if (rxs) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign rd_acc = iocs & iorw & (addr == 2'b00);
    assign pop    = rd_acc & !rd_acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_acc_q <= 1'b0;
        end else begin
            rd_acc_q <= rd_acc;
        end
    end

    assign bus_data = rd_acc ? head_data : 8'hzz;

`ifdef SPART_RX_FIFO_EN

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, full, do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = store & (!full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'h000;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            oerr   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {store_bad, shift};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            if (pop) begin
                oerr <= 1'b0;
            end else if (store && full) begin
                oerr <= 1'b1;
            end
        end
    end

    assign rda       = !empty;
    assign ferr      = !empty & mem[rd_ptr][8];
    assign head_data = mem[rd_ptr][7:0];

`else

    logic [7:0] data_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buf <= 8'h00;
            rda      <= 1'b0;
            ferr     <= 1'b0;
            oerr     <= 1'b0;
        end else begin
            if (pop) begin
                rda  <= 1'b0;
                ferr <= 1'b0;
                oerr <= 1'b0;
            end
            // a pop on the same edge frees the buffer for the new byte
            if (store && (pop || !rda)) begin
                data_buf <= shift;
                ferr     <= store_bad;
                rda      <= 1'b1;
            end else if (store) begin
                oerr <= 1'b1;
            end
        end
    end

    assign head_data = data_buf;

`endif

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: randomized frames against a queue-based receive model.
// Build with SPART_RX_FIFO_EN to exercise the FIFO variant.
module tb_spart_rx;

    localparam int ENDIV  = 4;
    localparam int BITCLK = 16 * ENDIV;
`ifdef SPART_RX_FIFO_EN
    localparam int MD = 4;
`else
    localparam int MD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] addr = 2'b00;
    tri1  [7:0] bus_data;
    logic       rda, ferr, oerr;
    logic       enable;

    int en_cnt = 0;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int t_start = 0;
    int t_rise = -1;
    int lat = 0;
    logic rda_d = 1'b0;
    logic frame_go = 1'b0;

    logic [8:0] q[$];
    logic       oerr_m = 1'b0;

    spart_rx dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .rxd(rxd),
        .iocs(iocs),
        .iorw(iorw),
        .addr(addr),
        .bus_data(bus_data),
        .rda(rda),
        .ferr(ferr),
        .oerr(oerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        en_cnt <= (en_cnt == ENDIV - 1) ? 0 : en_cnt + 1;
        cyc    <= cyc + 1;
    end

    assign enable = (en_cnt == ENDIV - 1);

    always @(negedge clk) begin
        if (rda && !rda_d) t_rise <= cyc;
        rda_d <= rda;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".rda"}, rda, q.size() != 0);
        chk({tag, ".ferr"}, ferr, (q.size() != 0) ? q[0][8] : 1'b0);
        chk({tag, ".oerr"}, oerr, oerr_m);
    endtask

    task automatic model_store(input logic [7:0] d, input logic bad);
        if (q.size() < MD) q.push_back({bad, d});
        else oerr_m = 1'b1;
    endtask

    task automatic model_pop();
        if (q.size() != 0) void'(q.pop_front());
        oerr_m = 1'b0;
    endtask

    task automatic wait_bit();
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic sync_start();
        @(negedge clk);
        while (en_cnt != 0) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        sync_start();
        t_start  = cyc;
        frame_go = 1'b1;
        rxd = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_bit();
        end
        rxd = stop;
        wait_bit();
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        send_frame(d, stop);
        model_store(d, !stop);
        if (!stop) begin
            rxd = 1'b1;
            wait_bit();
        end
    endtask

    task automatic do_read(input int hold);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; addr = 2'b00;
        #1;
        if (q.size() != 0) chk("rd_data", bus_data, q[0][7:0]);
        @(posedge clk);
        model_pop();
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
        #1;
        chk("bus_release", bus_data, 8'hFF);
        chk_status("after_rd");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, nb;
        logic       stop, hit;
        int         w;

        repeat (3) @(negedge clk);
        chk_status("reset");
        chk("reset.bus", bus_data, 8'hFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        iocs = 1'b1; iorw = 1'b1; addr = 2'b00;
        #1 chk("rst_stale", bus_data, 8'h00);
        @(posedge clk);
        model_pop();
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;

        // first frame: also measures frame-start to store latency
        t_rise = -1;
        rx_frame(8'h55, 1'b1);
        chk_status("f55");
        lat = t_rise - t_start;
        chk("lat_range", (lat >= 144 * ENDIV && lat <= 160 * ENDIV), 1);
        do_read(1);

        sync_start();
        rxd = 1'b0;
        repeat (4 * ENDIV) @(negedge clk);
        rxd = 1'b1;
        wait_bit();
        chk_status("glitch");
        d = 8'($urandom);
        rx_frame(d, 1'b1);
        chk_status("post_glitch");
        do_read(1);

        send_frame(8'hA3, 1'b0);
        model_store(8'hA3, 1'b1);
        repeat (12) wait_bit();
        chk_status("break");
        rxd = 1'b1;
        wait_bit();
        chk_status("break_end");
        do_read(1);

        for (int i = 0; i <= MD; i++) begin
            d = (MD == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1);
            rx_frame(d, 1'b1);
        end
        chk_status("overrun");
        for (int i = 0; i < MD; i++) do_read(1);

        rx_frame(8'h5A, 1'b1);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; addr = 2'b00;
        #1 chk("wr_bus", bus_data, 8'hFF);
        @(negedge clk);
        iorw = 1'b1; addr = 2'b01;
        #1 chk("addr1_bus", bus_data, 8'hFF);
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0; addr = 2'b00;
        chk_status("no_pop");

        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; addr = 2'b00;
        #1 chk("held_data", bus_data, 8'h5A);
        @(posedge clk);
        model_pop();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_status("held5");
        nb = 8'($urandom);
        rx_frame(nb, 1'b1);
        chk_status("held_frame");
        #1 chk("held_new", bus_data, nb);
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
        do_read(1);

        d = 8'($urandom);
        rx_frame(d, 1'b1);
        nb = ~d;
        frame_go = 1'b0;
        hit = 1'b0;
        fork
            send_frame(nb, 1'b1);
            begin
                w = 0;
                @(negedge clk);
                while (!(frame_go && cyc == t_start + lat - 1) &&
                       w < 20 * BITCLK) begin
                    @(negedge clk);
                    w++;
                end
                hit = frame_go && (cyc == t_start + lat - 1);
                iocs = 1'b1; iorw = 1'b1; addr = 2'b00;
                #1 chk("sim_old", bus_data, d);
                @(negedge clk);
                iocs = 1'b0; iorw = 1'b0;
            end
        join
        chk("sim_align", hit, 1'b1);
        model_pop();
        model_store(nb, 1'b0);
        chk_status("sim");
        do_read(1);

        rx_frame(8'hC3, 1'b0);
        chk_status("pre_rst");
        sync_start();
        rxd = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rxd = 1'($urandom);
            wait_bit();
        end
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
        oerr_m = 1'b0;
        chk_status("rst_mid");
        chk("rst_mid.bus", bus_data, 8'hFF);
        rst_n = 1'b1;
        repeat (2) wait_bit();
        chk_status("rst_idle");
        rx_frame(8'h3C, 1'b1);
        chk_status("f3c");
        do_read(1);

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rx_frame(d, stop);
            chk_status("rnd");
            if ($urandom_range(0, 1) == 1) do_read(1 + $urandom_range(0, 3));
        end
        for (int i = 0; i < MD + 1 && q.size() != 0; i++) do_read(1);
        chk_status("drained");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART. Deserialises the asynchronous RX line into bytes, using the 16x oversampling `enable` tick from baud_gen.
- Presents received data on the shared 8-bit internal bus at address 2'b00 (read).
- Exports status bits for the top-level status register mux.
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1).

Parameters:
- SAMPLE_TICK, 7: enable-tick index within a bit period at which the line is sampled (mid-bit of 0..15).
- FIFO_DEPTH, 4: receive FIFO entries; used only when SPART_RX_FIFO_EN is defined; power of 2, min 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  16x baud tick from baud_gen, one-cycle pulse
- rxd  input  1  serial receive line, idle high, asynchronous to clk
- iocs  input  1  chip select
- iorw  input  1  1 = read, 0 = write
- addr  input  2  register address; this block responds only to 2'b00
- bus_data  inout  8  internal data bus
- rda  output  1  receive data available
- ferr  output  1  framing error for the byte currently at the head of the buffer
- oerr  output  1  sticky overrun flag

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; sync flops = 1; tick count = 0; bit count = 0.
  - Buffer/FIFO cleared; rda = 0, ferr = 0, oerr = 0.
  - Reset mid-frame abandons the frame with no partial byte stored.
- Input synchroniser: rxd passes through a 2-flop synchroniser (rxs). Its latency is not visible at the bus.
- FSM advances only on cycles with enable = 1, except WAIT_HIGH, which also requires enable. Tick counter is 4 bits and wraps 15 -> 0.
- FSM states:
  - IDLE: on an enable cycle with rxs = 0 -> START, tick = 0.
  - START: tick increments per enable. At tick == SAMPLE_TICK: rxs = 0 -> DATA with tick = 0 and bit = 0; rxs = 1 -> IDLE (glitch rejected, nothing stored).
  - DATA: at tick == 15, sample rxs into shift[bit] (LSB first) and increment bit; after bit 7 -> STOP with tick = 0. Samples occur 16 ticks apart, each centred in its bit.
  - STOP: at tick == 15, sample rxs. rxs = 1 -> frame good; rxs = 0 -> frame bad, store it anyway with ferr tag, then -> WAIT_HIGH. Otherwise -> IDLE.
  - WAIT_HIGH: stay until an enable cycle with rxs = 1, then -> IDLE. This prevents a held-low break line from producing repeated frames.
- Store, without SPART_RX_FIFO_EN (single buffer):
  - If rda = 0: data_buf <= shift, ferr <= frame bad, rda <= 1.
  - If rda = 1: byte discarded, oerr <= 1, data_buf and ferr unchanged.
- Read access: iocs & iorw & addr == 2'b00.
  - bus_data is driven combinationally with data_buf (FIFO head) while the access is asserted, otherwise 8'hzz.
  - With rda = 0, the stale data_buf value is driven (8'h00 after reset).
- Pop: occurs on the first clk edge of a read access (access asserted now, not asserted the previous cycle). Held accesses pop once.
  - Pop clears rda and ferr, and clears oerr.
- Simultaneous store and pop on the same edge:
  - The pop applies to the old byte.
  - The new byte is loaded, rda stays 1, no overrun.
- Writes (iorw = 0) and other addresses: ignored; bus_data is not driven.

Optional Feature:
SPART_RX_FIFO_EN:
- Defined: the single buffer is replaced by a FIFO_DEPTH-entry FIFO of {ferr, data[7:0]}.
  - rda = not empty; ferr = ferr bit of the head entry.
  - Store on full -> byte discarded, oerr <= 1.
  - Pop removes the head; oerr clears on pop.
  - Store and pop on the same edge when full: both succeed, count unchanged, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: single buffer as described in Behaviour.

Test Plan:
- Divisor 0x00A2 (bit = 16*163 clocks); send 0x55 with a good stop bit -> rda = 1 after the stop-bit sample, ferr = 0; read addr 00 returns 0x55; rda = 0 the next cycle.
- rxd low pulse of 4 ticks then high -> START rejects it at tick 7; rda stays 0; FSM back in IDLE.
- Send 0xA3 with stop bit = 0, then hold rxd low for 3 bit times -> exactly one store (0xA3, ferr = 1); no further frames until rxd returns high.
- Single buffer: send 0x11 then 0x22 without reading -> oerr = 1; read returns 0x11; oerr = 0 and rda = 0 after the read.
- Read access held 5 cycles while a byte is pending -> exactly one pop. Pop on the same edge as a store -> rda stays 1, and the next read returns the new byte.
- SPART_RX_FIFO_EN with FIFO_DEPTH = 4: send 0x01..0x05 with no reads -> oerr = 1; reads return 0x01..0x04; rda = 0 after the 4th read.
- Assert rst_n low during the DATA state -> all outputs 0 and bus tri-stated; the next full frame of 0x3C is received correctly.
